// File: rtl/uart_tx_if.sv
// Byte handshake between an upstream producer and the UART transmitter.
//   tx_valid : producer has a byte to send
//   tx_data  : byte to send, sampled only when tx_valid && tx_ready
//   tx_ready : transmitter can accept a byte (idle)
// master = producer side, slave = transmitter side.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// Serial UART transmitter. Accepts one byte over the bus handshake and sends
// it LSB-first as: start bit, DATA_BITS data bits, optional parity bit,
// STOP_BITS stop bits. Each bit lasts OVERSAMPLE strobes of the external
// baud strobe `tick`; the block holds no baud divider of its own.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (aborts any frame, line idles high)
//   tick  : one-cycle baud strobe
//   bus   : slave side of the valid/ready byte handshake
//   busy  : a frame is in progress
//   tx    : registered serial line, idle high
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0,
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     tick,
    uart_tx_if.slave bus,
    output logic     busy,
    output logic     tx
);
    // A one-bit counter is kept for OVERSAMPLE=1; it simply stays at zero.
    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;

    assign bit_end = tick && (tick_cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tx_d       = tx_q;

        // Sub-bit counter runs only inside a frame; the tick of the transfer
        // cycle is dropped because IDLE forces the counter to zero.
        if (state_q != ST_IDLE && tick) begin
            tick_cnt_d = (tick_cnt_q == CNT_LAST) ? '0 : tick_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (bus.tx_valid) begin
                    shift_d    = bus.tx_data;
                    par_d      = (PARITY == 1) ? ~(^bus.tx_data) : ^bus.tx_data;
                    tx_d       = 1'b0;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        // Counter is reused for stop bits.
                        bit_cnt_d = '0;
                        if (PARITY != 0) begin
                            tx_d    = par_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

    assign bus.tx_ready = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign tx           = tx_q;
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the peripheral subsystem. It accepts one byte at a time over a valid/ready handshake and shifts it out LSB-first as an asynchronous frame: start bit, data bits, optional parity, stop bit(s). Bit timing comes from an external one-cycle baud strobe, `tick`, driven by the baud-rate prescaler counter's `last` output. The block itself holds no baud divider.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame, legal range 5..8.
- `STOP_BITS`, default 1: stop bits per frame, legal values 1 or 2.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `OVERSAMPLE`, default 16: `tick` strobes per serial bit, ≥ 1.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  baud strobe; one-cycle pulse, any rate ≤ 1 per `clk`.
- `tx_valid`  in  1  upstream has a byte to send.
- `tx_data`  in  `DATA_BITS`  byte to send; sampled only on transfer.
- `tx_ready`  out  1  block can accept a byte.
- `busy`  out  1  a frame is in progress.
- `tx`  out  1  serial line; idle high, registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- `tick_cnt` is a `$clog2(OVERSAMPLE)`-bit sub-bit counter. It increments on `tick` and wraps at `OVERSAMPLE-1`.
- A "bit end" is a cycle where `tick`=1 and `tick_cnt==OVERSAMPLE-1`.
- `bit_cnt` counts data or stop bits.
- IDLE: `tx_ready`=1, `busy`=0, `tx`=1; `tick` is ignored.
- A transfer occurs when `tx_valid && tx_ready`. On that edge the block:
  - latches `tx_data` into the shift register;
  - computes parity over the latched data (odd: XOR inverted; even: XOR);
  - sets `tx` to 0 and `tick_cnt` and `bit_cnt` to 0;
  - moves to START.
- START: on bit end → DATA; `tx` = data[0].
- DATA: on bit end, shift right and increment `bit_cnt`.
  - When bit `DATA_BITS-1` ends → PARITY if `PARITY!=0` (`tx` = parity bit), else → STOP (`tx`=1).
- PARITY: on bit end → STOP, `tx`=1.
- STOP: on bit end, increment `bit_cnt`.
  - When stop bit `STOP_BITS` ends → IDLE.
- `tx_ready` is 1 only in IDLE. `busy` = !IDLE. Both are decoded from state, so they are glitch-free registered-state functions.
- `tx_data` changes while not ready are ignored. The latched frame is immutable until the frame ends.

## Timing
- Reset values: state IDLE, `tx`=1, `tx_ready`=1, `busy`=0, `tick_cnt`=0, `bit_cnt`=0, shift register 0.
- Reset mid-frame: the frame aborts immediately and `tx` returns to 1 asynchronously. There is no resumption.
- Transfer-to-line latency: `tx` falls on the transfer clock edge itself and is visible the following cycle.
- Frame length: (1 + `DATA_BITS` + (`PARITY`?1:0) + `STOP_BITS`) × `OVERSAMPLE` ticks.
- The start bit additionally includes the partial interval from transfer to the first `tick`.
- A `tick` in the transfer cycle is not counted toward the start bit.
- Every later bit lasts exactly `OVERSAMPLE` ticks, with its edge aligned to the bit-end cycle.
- Back-to-back frames: STOP→IDLE on the final bit end. `tx_ready`=1 in the next cycle.
  - If `tx_valid` is held, the next start bit begins 1 cycle after the final bit end. The minimum idle gap is one `clk`.
- No `tick` while busy: the FSM holds state and the line stays constant indefinitely.
- `OVERSAMPLE`=1: every `tick` is a bit end.

## Test plan
- Reset, then no stimulus for 100 cycles → `tx`=1, `tx_ready`=1, `busy`=0 throughout; ticks ignored.
- Defaults with `OVERSAMPLE`=4 and `tick` every cycle; send 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; `tx_ready` returns 1 after 40 cycles.
- `PARITY`=2, `STOP_BITS`=2; send 0x07 → data 1,1,1,0,0,0,0,0; parity 1; two stop bits; frame 12 bit-times.
- `tx_valid` held high with 0x00 then 0xFF and `tick` every 3rd cycle → two frames with a 1-cycle idle gap; `tx_data` changes mid-frame do not alter the line.
- Assert `rst_n` low during data bit 3, then release → `tx`=1 immediately, IDLE, `tx_ready`=1; the next transfer sends a clean full frame.
- Stall `tick` for 50 cycles mid-frame → line and state frozen; the frame completes correctly once ticks resume.
